// File: rtl/bcd_down_timer_pkg.sv
// Shared BCD constants and the load-time digit clamp
// for the multi-decade down timer.
package bcd_down_timer_pkg;

    localparam int        BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Digits above 9 become 9 when clamping is enabled.
    function automatic logic [BCD_W-1:0] bcd_clamp(
        input logic [BCD_W-1:0] d,
        input logic             clamp_en
    );
        logic [BCD_W-1:0] r;
        r = d;
        if (clamp_en && (d > BCD_MAX)) begin
            r = BCD_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_down_timer_digit.sv
// One BCD decade with synchronous load and a borrow
// output toward the next more significant decade.
module bcd_digit_down
    import bcd_down_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec_in,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= BCD_ZERO;
        end else if (load) begin
            digit <= load_val;
        end else if (dec_in) begin
            if (digit == BCD_ZERO) begin
                digit <= BCD_MAX;
            end else begin
                digit <= digit - 4'd1;
            end
        end
    end

    assign borrow_out = dec_in & (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-decade BCD down timer with load, pause,
// one-shot / auto-reload modes and a done pulse.
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter bit CLAMP_BCD = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
    input  logic                      en,
    input  logic                      hold,
    input  logic                      auto_reload,
    output logic [BCD_W*DIGITS-1:0]   count,
    output logic                      running,
    output logic                      zero,
    output logic                      done
);

    localparam int CW = BCD_W * DIGITS;
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] clamped;
    logic [CW-1:0] reload_reg;
    logic [CW-1:0] dig_val;
    logic [DIGITS:0] dec;
    logic          tick;
    logic          expire;
    logic          reload_now;
    logic          dig_load;

    assign tick       = en & running & ~hold;
    assign expire     = tick & (count == ONE);
    assign reload_now = expire & auto_reload & ~load;
    assign dig_load   = load | reload_now;
    assign dig_val    = load ? clamped : reload_reg;
    assign dec[0]     = tick & ~load;
    assign zero       = (count == '0);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            assign clamped[g*BCD_W +: BCD_W] =
                bcd_clamp(load_val[g*BCD_W +: BCD_W],
                          CLAMP_BCD);

            bcd_digit_down u_digit (
                .clk        (clk),
                .rst        (rst),
                .load       (dig_load),
                .load_val   (dig_val[g*BCD_W +: BCD_W]),
                .dec_in     (dec[g]),
                .digit      (count[g*BCD_W +: BCD_W]),
                .borrow_out (dec[g+1])
            );
        end
    endgenerate

    // Top-decade borrow only fires when counting below 0,
    // which expiry handling prevents.
    logic unused_borrow;
    assign unused_borrow = dec[DIGITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_reg <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
        end else if (load) begin
            reload_reg <= clamped;
            running    <= (clamped != '0);
            done       <= 1'b0;
        end else begin
            done <= expire;
            if (expire && !auto_reload) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed scoreboard bench for bcd_down_timer
// (DIGITS=4, CLAMP_BCD=1).
module tb_bcd_down_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic        en = 1'b0;
    logic        hold = 1'b0;
    logic        auto_reload = 1'b0;
    logic [15:0] count;
    logic        running;
    logic        zero;
    logic        done;

    bcd_down_timer #(
        .DIGITS    (4),
        .CLAMP_BCD (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .hold        (hold),
        .auto_reload (auto_reload),
        .count       (count),
        .running     (running),
        .zero        (zero),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cnt;
        logic        run;
        logic        dn;
        logic        zr;
        string       tag;
    } exp_t;

    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    int m_cnt = 0;
    int m_rl = 0;
    bit m_run = 0;
    bit m_done = 0;

    function automatic int bcd2int(input logic [15:0] v);
        int s;
        int w;
        int d;
        s = 0;
        w = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            s = s + d * w;
            w = w * 10;
        end
        return s;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        int x;
        x = n;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk1(input string tag, input string f,
                        input logic o, input logic e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s.%s got %b want %b", tag, f, o, e);
        end
    endtask

    task automatic step(input bit r, input bit l,
                        input logic [15:0] lv, input bit e,
                        input bit h, input bit a,
                        input string tag);
        exp_t x;
        exp_t y;
        rst = r;
        load = l;
        load_val = lv;
        en = e;
        hold = h;
        auto_reload = a;
        if (r) begin
            m_cnt = 0; m_rl = 0; m_run = 0; m_done = 0;
        end else if (l) begin
            m_cnt = bcd2int(lv);
            m_rl = m_cnt;
            m_run = (m_cnt != 0);
            m_done = 0;
        end else if (e && m_run && !h) begin
            if (m_cnt == 1) begin
                m_done = 1;
                if (a) m_cnt = m_rl;
                else begin m_cnt = 0; m_run = 0; end
            end else begin
                m_cnt = m_cnt - 1;
                m_done = 0;
            end
        end else begin
            m_done = 0;
        end
        x.cnt = int2bcd(m_cnt);
        x.run = m_run;
        x.dn = m_done;
        x.zr = (m_cnt == 0);
        x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        rst = 0; load = 0; en = 0;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            y = sb.pop_front();
            vectors++;
            assert (count === y.cnt) else begin
                miscompares++;
                $error("FAIL %s.count got %h want %h",
                       y.tag, count, y.cnt);
            end
            chk1(y.tag, "running", running, y.run);
            chk1(y.tag, "done", done, y.dn);
            chk1(y.tag, "zero", zero, y.zr);
        end
    endtask

    int npulse;

    initial begin
        @(negedge clk);
        step(1, 1, 16'h0042, 1, 0, 0, "reset");
        step(1, 0, 16'h0000, 0, 0, 0, "reset2");

        step(0, 1, 16'h0012, 0, 0, 0, "t2_load");
        for (int i = 0; i < 12; i++)
            step(0, 0, 16'h0, 1, 0, 0, "t2_tick");
        step(0, 0, 16'h0, 1, 0, 0, "t2_after");
        step(0, 0, 16'h0, 1, 0, 0, "t2_after2");

        step(0, 1, 16'h0100, 0, 0, 0, "t3_load");
        step(0, 0, 16'h0, 1, 0, 0, "t3_borrow");
        vectors++;
        assert (count === 16'h0099) else begin
            miscompares++;
            $error("FAIL t3_0099 got %h want 0099", count);
        end
        for (int i = 0; i < 99; i++)
            step(0, 0, 16'h0, 1, 0, 0, "t3_tick");
        step(0, 0, 16'h0, 0, 0, 0, "t3_idle");

        step(0, 1, 16'h0003, 0, 0, 1, "t4_load");
        npulse = 0;
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 16'h0, 1, 0, 1, "t4_tick");
            if (done) npulse++;
        end
        vectors++;
        assert (npulse == 3) else begin
            miscompares++;
            $error("FAIL t4_pulses got %0d want 3", npulse);
        end
        step(0, 0, 16'h0, 1, 0, 0, "t4_tick");
        step(0, 0, 16'h0, 1, 0, 0, "t4_tick");
        step(0, 0, 16'h0, 1, 0, 0, "t4_oneshot");

        step(0, 1, 16'h0005, 0, 0, 0, "t5_load");
        for (int i = 0; i < 4; i++)
            step(0, 0, 16'h0, 1, 1, 0, "t5_hold");
        for (int i = 0; i < 5; i++)
            step(0, 0, 16'h0, 1, 0, 0, "t5_tick");
        step(0, 0, 16'h0, 1, 0, 0, "t5_after");

        step(0, 1, 16'h00A7, 0, 0, 0, "t6_clamp");
        step(0, 1, 16'h9F9E, 0, 0, 0, "t6_clamp2");
        step(0, 1, 16'h0000, 0, 0, 0, "t6_zero");
        step(0, 0, 16'h0, 1, 0, 0, "t6_zero_tick");
        step(0, 1, 16'h0002, 0, 0, 0, "t6_load2");
        step(0, 0, 16'h0, 1, 0, 0, "t6_tick");
        step(0, 1, 16'h0042, 1, 0, 0, "t6_coincide");
        step(0, 0, 16'h0, 0, 0, 0, "t6_idle");
        step(0, 0, 16'h0, 1, 0, 0, "t6_tick2");
        step(1, 0, 16'h0, 1, 0, 0, "t6_rst_mid");

        step(0, 1, 16'h9999, 0, 0, 0, "t7_max");
        step(0, 0, 16'h0, 1, 0, 0, "t7_tick");
        step(0, 1, 16'h1000, 0, 0, 0, "t7_1000");
        step(0, 0, 16'h0, 1, 0, 0, "t7_borrow3");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
